// File: rtl/cla_pipe_adder_if.sv
// Operand/result handshake bundle for the pipelined carry-lookahead adder.
// The slave side is the adder; the master side is the issue/writeback logic.
interface cla_pipe_adder_if #(
    parameter int W = 64
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/cla_pipe_adder.sv
// Wide adder pipelined one 16-bit carry-lookahead slice per stage, with a
// bit-level p/g input stage and a registered result stage behind the last slice.
module cla_pipe_adder #(
    parameter int SLICES = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    cla_pipe_adder_if.slave bus
);
    localparam int W = 16 * SLICES;

    logic adv;

    // Stage 0 holds raw p/g; stage k (1..SLICES) has resolved slices 0..k-1.
    logic [SLICES:0]            st_valid;
    logic [SLICES-1:0][W-1:0]   st_p;
    logic [SLICES-1:0][W-1:0]   st_g;
    logic [SLICES:0][W-1:0]     st_sum;
    logic [SLICES:0]            st_carry;
    logic                       last_c15;

    logic                       out_valid_r;
    logic [W-1:0]               sum_r;
    logic                       cout_r;
    logic                       ovf_r;

    logic [SLICES:1][17:0]      res;
    logic [SLICES:1][W-1:0]     nxt_sum;

    // Returns {carry out of bit 15, carry into bit 15, sum[15:0]}.
    function automatic logic [17:0] cla16(
        input logic [15:0] p,
        input logic [15:0] g,
        input logic        ci
    );
        logic [3:0]  gp;
        logic [3:0]  gg;
        logic [4:0]  gc;
        logic [15:0] c;
        for (int j = 0; j < 4; j++) begin
            gp[j] = p[4*j+3] & p[4*j+2] & p[4*j+1] & p[4*j];
            gg[j] = g[4*j+3]
                  | (p[4*j+3] & g[4*j+2])
                  | (p[4*j+3] & p[4*j+2] & g[4*j+1])
                  | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
        end
        gc[0] = ci;
        gc[1] = gg[0] | (gp[0] & gc[0]);
        gc[2] = gg[1] | (gp[1] & gc[1]);
        gc[3] = gg[2] | (gp[2] & gc[2]);
        gc[4] = gg[3] | (gp[3] & gc[3]);
        // Bit carries inside each group come straight from the group carry-in.
        for (int j = 0; j < 4; j++) begin
            c[4*j]   = gc[j];
            c[4*j+1] = g[4*j] | (p[4*j] & gc[j]);
            c[4*j+2] = g[4*j+1]
                     | (p[4*j+1] & g[4*j])
                     | (p[4*j+1] & p[4*j] & gc[j]);
            c[4*j+3] = g[4*j+2]
                     | (p[4*j+2] & g[4*j+1])
                     | (p[4*j+2] & p[4*j+1] & g[4*j])
                     | (p[4*j+2] & p[4*j+1] & p[4*j] & gc[j]);
        end
        return {gc[4], c[15], p ^ c};
    endfunction

    always_comb begin
        res     = '0;
        nxt_sum = '0;
        for (int k = 1; k <= SLICES; k++) begin
            res[k] = cla16(st_p[k-1][16*(k-1) +: 16],
                           st_g[k-1][16*(k-1) +: 16],
                           st_carry[k-1]);
            nxt_sum[k] = st_sum[k-1];
            nxt_sum[k][16*(k-1) +: 16] = res[k][15:0];
        end
    end

    // Global stall: every stage moves together or nothing moves.
    assign adv = !out_valid_r || bus.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_valid    <= '0;
            st_p        <= '0;
            st_g        <= '0;
            st_sum      <= '0;
            st_carry    <= '0;
            last_c15    <= 1'b0;
            out_valid_r <= 1'b0;
            sum_r       <= '0;
            cout_r      <= 1'b0;
            ovf_r       <= 1'b0;
        end else if (adv) begin
            st_valid[0] <= bus.in_valid;
            st_p[0]     <= bus.a ^ bus.b;
            st_g[0]     <= bus.a & bus.b;
            st_carry[0] <= bus.cin;
            st_sum[0]   <= '0;
            for (int k = 1; k < SLICES; k++) begin
                st_p[k] <= st_p[k-1];
                st_g[k] <= st_g[k-1];
            end
            for (int k = 1; k <= SLICES; k++) begin
                st_valid[k] <= st_valid[k-1];
                st_sum[k]   <= nxt_sum[k];
                st_carry[k] <= res[k][17];
            end
            // Only the top slice's bit-15 carry-in matters for signed overflow.
            last_c15    <= res[SLICES][16];
            out_valid_r <= st_valid[SLICES];
            sum_r       <= st_sum[SLICES];
            cout_r      <= st_carry[SLICES];
            ovf_r       <= last_c15 ^ st_carry[SLICES];
        end
    end

    assign bus.in_ready  = adv;
    assign bus.out_valid = out_valid_r;
    assign bus.sum       = sum_r;
    assign bus.cout      = cout_r;
    assign bus.ovf       = ovf_r;

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Random and directed stimulus for cla_pipe_adder, checked each cycle against
// a queue-based model of a fixed-depth, globally stalled pipeline.
module tb_cla_pipe_adder;
    localparam int SLICES = 4;
    localparam int W      = 16 * SLICES;
    localparam int CW     = W + 1;
    localparam int DEPTH  = SLICES + 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cla_pipe_adder_if #(.W(W)) bus ();

    cla_pipe_adder #(.SLICES(SLICES)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } res_t;

    res_t exp_q[$];
    int   age_q[$];
    int   checks = 0;
    int   errors = 0;

    function automatic res_t ref_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                     input logic ci);
        logic [W:0] t;
        res_t       r;
        t      = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
        r.sum  = t[W-1:0];
        r.cout = t[W];
        r.ovf  = (a[W-1] == b[W-1]) && (r.sum[W-1] != a[W-1]);
        return r;
    endfunction

    function automatic void check(input string name, input logic [CW-1:0] act,
                                  input logic [CW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic logic [W-1:0] rand_op();
        logic [W-1:0] r;
        r = {$urandom, $urandom};
        case ($urandom_range(0, 3))
            1: r = ~(r & {{(W-8){1'b0}}, 8'hFF});
            2: r = r & {{(W-32){1'b0}}, 32'hFFFF_FFFF};
            default: ;
        endcase
        return r;
    endfunction

    // Model: every item ages one position per advancing edge; the oldest is
    // visible at the output once it has travelled DEPTH positions.
    always @(negedge clk) begin : mon
        logic exp_ov;
        logic adv_m;
        res_t e;
        if (!rst_n) begin
            exp_q.delete();
            age_q.delete();
        end else begin
            exp_ov = (age_q.size() > 0) && (age_q[0] == DEPTH);
            adv_m  = !exp_ov || bus.out_ready;
            check("out_valid", CW'(bus.out_valid), CW'(exp_ov));
            check("in_ready", CW'(bus.in_ready), CW'(adv_m));
            if (exp_ov) begin
                e = exp_q[0];
                check("sum", CW'(bus.sum), CW'(e.sum));
                check("cout", CW'(bus.cout), CW'(e.cout));
                check("ovf", CW'(bus.ovf), CW'(e.ovf));
                if (bus.out_ready) begin
                    void'(exp_q.pop_front());
                    void'(age_q.pop_front());
                end
            end
            if (adv_m) foreach (age_q[i]) age_q[i]++;
            if (adv_m && bus.in_valid) begin
                exp_q.push_back(ref_add(bus.a, bus.b, bus.cin));
                age_q.push_back(1);
            end
        end
    end

    task automatic cyc(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic ci, input logic ordy);
        bus.in_valid  = v;
        bus.a         = a;
        bus.b         = b;
        bus.cin       = ci;
        bus.out_ready = ordy;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, '0, '0, 1'b0, 1'b1);
    endtask

    task automatic directed(input string name, input logic [W-1:0] a,
                            input logic [W-1:0] b, input logic ci,
                            input logic [W-1:0] es, input logic ec, input logic eo);
        res_t r;
        int   n;
        r = ref_add(a, b, ci);
        check({name, "_model_sum"}, CW'(r.sum), CW'(es));
        check({name, "_model_cout"}, CW'(r.cout), CW'(ec));
        check({name, "_model_ovf"}, CW'(r.ovf), CW'(eo));
        cyc(1'b1, a, b, ci, 1'b1);
        bus.in_valid = 1'b0;
        n = 0;
        while (!bus.out_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({name, "_latency"}, CW'(n), CW'(SLICES + 1));
        check({name, "_sum"}, CW'(bus.sum), CW'(es));
        check({name, "_cout"}, CW'(bus.cout), CW'(ec));
        check({name, "_ovf"}, CW'(bus.ovf), CW'(eo));
        idle(2);
    endtask

    initial begin : watchdog
        #100000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin : stim
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.cin       = 1'b0;
        bus.out_ready = 1'b1;
        #1;
        check("rst_out_valid", CW'(bus.out_valid), CW'(0));
        check("rst_sum", CW'(bus.sum), CW'(0));
        check("rst_cout", CW'(bus.cout), CW'(0));
        check("rst_ovf", CW'(bus.ovf), CW'(0));
        check("rst_in_ready", CW'(bus.in_ready), CW'(1));
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(2);

        directed("carry_all", 64'h0000_0000_0000_0001, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0,
                 64'h0, 1'b1, 1'b0);
        directed("pos_ovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0001, 1'b0,
                 64'h8000_0000_0000_0000, 1'b0, 1'b1);
        directed("cin_only", 64'h0, 64'h0, 1'b1, 64'h1, 1'b0, 1'b0);
        directed("neg_ovf", 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0,
                 64'h0, 1'b1, 1'b1);

        // back-to-back stream
        for (int i = 0; i < 8; i++) cyc(1'b1, rand_op(), rand_op(), 1'($urandom), 1'b1);
        idle(8);

        // fill, stall three cycles, resume
        for (int i = 0; i < 7; i++) cyc(1'b1, rand_op(), rand_op(), 1'($urandom), 1'b1);
        for (int i = 0; i < 3; i++) cyc(1'b1, rand_op(), rand_op(), 1'($urandom), 1'b0);
        for (int i = 0; i < 4; i++) cyc(1'b1, rand_op(), rand_op(), 1'($urandom), 1'b1);
        idle(10);

        // bubble pattern 1,0,1,1,0
        cyc(1'b1, rand_op(), rand_op(), 1'($urandom), 1'b1);
        cyc(1'b0, rand_op(), rand_op(), 1'($urandom), 1'b1);
        cyc(1'b1, rand_op(), rand_op(), 1'($urandom), 1'b1);
        cyc(1'b1, rand_op(), rand_op(), 1'($urandom), 1'b1);
        cyc(1'b0, rand_op(), rand_op(), 1'($urandom), 1'b1);
        idle(10);

        // reset with transactions in flight and one at the output
        for (int i = 0; i < 6; i++) cyc(1'b1, rand_op(), rand_op(), 1'($urandom), 1'b1);
        bus.in_valid = 1'b0;
        check("pre_reset_out_valid", CW'(bus.out_valid), CW'(1));
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", CW'(bus.out_valid), CW'(0));
        check("midrst_sum", CW'(bus.sum), CW'(0));
        check("midrst_cout", CW'(bus.cout), CW'(0));
        check("midrst_ovf", CW'(bus.ovf), CW'(0));
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        idle(12);

        // random traffic with random backpressure
        for (int i = 0; i < 400; i++)
            cyc(1'($urandom_range(0, 3) != 0), rand_op(), rand_op(), 1'($urandom),
                1'($urandom_range(0, 3) != 0));
        idle(20);
        check("drained", CW'(exp_q.size()), CW'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
